// File: rtl/shop_item_arb_if.sv
// Request/response bundle between the shop command front-ends
// and the shared item-table arbiter.
interface shop_item_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int NAME_BITS  = 56,
  parameter int U_BITS     = 4,
  parameter int STOCK_BITS = 8
);
  logic [NUM_REQ-1:0]            i_req;
  logic [2*NUM_REQ-1:0]          i_op;
  logic [NAME_BITS*NUM_REQ-1:0]  i_name;
  logic [U_BITS*NUM_REQ-1:0]     i_user;
  logic [STOCK_BITS*NUM_REQ-1:0] i_qty;
  logic [NUM_REQ-1:0]            o_ack;
  logic [2:0]                    o_status;
  logic [STOCK_BITS-1:0]         o_stock;
  logic                          o_busy;
  logic [1:0]                    o_grant;

  modport master (
    output i_req, i_op, i_name, i_user, i_qty,
    input  o_ack, o_status, o_stock, o_busy, o_grant
  );

  modport slave (
    input  i_req, i_op, i_name, i_user, i_qty,
    output o_ack, o_status, o_stock, o_busy, o_grant
  );
endinterface

// File: rtl/shop_item_arb.sv
// Shared item table with round-robin arbitration: each grant runs
// a linear scan of the table, one update cycle, then an ack cycle.
module shop_item_arb #(
  parameter int NUM_REQ    = 2,
  parameter int MAX_ITEMS  = 4,
  parameter int NAME_BITS  = 56,
  parameter int U_BITS     = 4,
  parameter int STOCK_BITS = 8
) (
  input logic            i_clk,
  input logic            i_reset,
  shop_item_arb_if.slave bus
);
  localparam int IW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

  localparam logic [1:0] OP_FIND = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_DEL  = 2'd2;
  localparam logic [1:0] OP_BUY  = 2'd3;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_UNKNOWN = 3'd1;
  localparam logic [2:0] ST_EXISTS  = 3'd2;
  localparam logic [2:0] ST_FULL    = 3'd3;
  localparam logic [2:0] ST_NOTYOUR = 3'd4;
  localparam logic [2:0] ST_NOSTOCK = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, EXEC, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]            rr, grant, win;
  logic                  win_vld;
  logic [1:0]            sel_op, op;
  logic [NAME_BITS-1:0]  sel_name, name;
  logic [U_BITS-1:0]     sel_user, user;
  logic [STOCK_BITS-1:0] sel_qty, qty;
  logic [IW-1:0]         idx, hit_idx, free_idx;
  logic                  hit, free, last;

  logic [MAX_ITEMS-1:0]  t_vld;
  logic [NAME_BITS-1:0]  t_name [MAX_ITEMS];
  logic [U_BITS-1:0]     t_own  [MAX_ITEMS];
  logic [STOCK_BITS-1:0] t_stk  [MAX_ITEMS];

  logic [2:0]            status;
  logic [STOCK_BITS-1:0] stock;

  assign last = (idx == IW'(MAX_ITEMS - 1));

  // Search order starts at rr and wraps, so the first hit is the winner.
  always_comb begin
    win_vld  = 1'b0;
    win      = '0;
    sel_op   = '0;
    sel_name = '0;
    sel_user = '0;
    sel_qty  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_vld && bus.i_req[j] &&
            ((int'(rr) + i) % NUM_REQ) == j) begin
          win_vld  = 1'b1;
          win      = 2'(j);
          sel_op   = bus.i_op[j*2 +: 2];
          sel_name = bus.i_name[j*NAME_BITS +: NAME_BITS];
          sel_user = bus.i_user[j*U_BITS +: U_BITS];
          sel_qty  = bus.i_qty[j*STOCK_BITS +: STOCK_BITS];
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win_vld) state_nx = SCAN;
      SCAN:    if (last) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr       <= '0;
      grant    <= '0;
      op       <= '0;
      name     <= '0;
      user     <= '0;
      qty      <= '0;
      idx      <= '0;
      hit      <= 1'b0;
      free     <= 1'b0;
      hit_idx  <= '0;
      free_idx <= '0;
    end else begin
      if (state == IDLE && win_vld) begin
        grant    <= win;
        rr       <= (int'(win) == NUM_REQ - 1) ? 2'd0 : win + 2'd1;
        op       <= sel_op;
        name     <= sel_name;
        user     <= sel_user;
        qty      <= sel_qty;
        idx      <= '0;
        hit      <= 1'b0;
        free     <= 1'b0;
        hit_idx  <= '0;
        free_idx <= '0;
      end
      if (state == SCAN) begin
        if (t_vld[idx] && t_name[idx] == name && !hit) begin
          hit     <= 1'b1;
          hit_idx <= idx;
        end
        if (!t_vld[idx] && !free) begin
          free     <= 1'b1;
          free_idx <= idx;
        end
        idx <= idx + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      t_vld  <= '0;
      status <= ST_OK;
      stock  <= '0;
      for (int i = 0; i < MAX_ITEMS; i++) begin
        t_name[i] <= '0;
        t_own[i]  <= '0;
        t_stk[i]  <= '0;
      end
    end else if (state == EXEC) begin
      unique case (op)
        OP_FIND: begin
          if (hit) begin
            status <= ST_OK;
            stock  <= t_stk[hit_idx];
          end else begin
            status <= ST_UNKNOWN;
            stock  <= '0;
          end
        end
        OP_ADD: begin
          if (hit) begin
            status <= ST_EXISTS;
            stock  <= t_stk[hit_idx];
          end else if (!free) begin
            status <= ST_FULL;
            stock  <= '0;
          end else begin
            t_vld[free_idx]  <= 1'b1;
            t_name[free_idx] <= name;
            t_own[free_idx]  <= user;
            t_stk[free_idx]  <= qty;
            status           <= ST_OK;
            stock            <= qty;
          end
        end
        OP_DEL: begin
          if (!hit) begin
            status <= ST_UNKNOWN;
            stock  <= '0;
          end else if (t_own[hit_idx] != user && user != '0) begin
            status <= ST_NOTYOUR;
            stock  <= t_stk[hit_idx];
          end else begin
            t_vld[hit_idx] <= 1'b0;
            status         <= ST_OK;
            stock          <= '0;
          end
        end
        OP_BUY: begin
          if (!hit) begin
            status <= ST_UNKNOWN;
            stock  <= '0;
          end else if (t_stk[hit_idx] < qty) begin
            status <= ST_NOSTOCK;
            stock  <= t_stk[hit_idx];
          end else begin
            t_stk[hit_idx] <= t_stk[hit_idx] - qty;
            status         <= ST_OK;
            stock          <= t_stk[hit_idx] - qty;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.o_ack[i] = (state == DONE) && (int'(grant) == i);
  end

  assign bus.o_busy   = (state != IDLE);
  assign bus.o_grant  = grant;
  assign bus.o_status = status;
  assign bus.o_stock  = stock;
endmodule

// File: tb/tb_shop_item_arb.sv
// Directed bench for shop_item_arb: vector table for single ops,
// hand sequences for latency, arbitration ties and mid-op reset.
module tb_shop_item_arb;
  localparam int NR = 2;
  localparam int NB = 56;
  localparam int UB = 4;
  localparam int SB = 8;

  logic i_clk = 1'b0;
  logic i_reset;

  shop_item_arb_if #(
    .NUM_REQ(NR), .NAME_BITS(NB), .U_BITS(UB), .STOCK_BITS(SB)
  ) bus ();

  shop_item_arb #(
    .NUM_REQ(NR), .MAX_ITEMS(4), .NAME_BITS(NB),
    .U_BITS(UB), .STOCK_BITS(SB)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [NB-1:0] nm;
    logic [UB-1:0] u;
    logic [SB-1:0] q;
    logic [2:0] st;
    logic [SB-1:0] stk;
    bit         ck_stk;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic [1:0] op,
                       input logic [NB-1:0] nm, input logic [UB-1:0] u,
                       input logic [SB-1:0] q);
    bus.i_op[r*2 +: 2]     = op;
    bus.i_name[r*NB +: NB] = nm;
    bus.i_user[r*UB +: UB] = u;
    bus.i_qty[r*SB +: SB]  = q;
    bus.i_req[r]           = 1'b1;
  endtask

  task automatic wait_ack(input string tag, output logic [NR-1:0] a);
    bit seen;
    seen = 1'b0;
    a = '0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_ack != '0) begin
        seen = 1'b1;
        a = bus.o_ack;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within 30 cycles", tag);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [NR-1:0] a;
    @(negedge i_clk);
    drive(v.r, v.op, v.nm, v.u, v.q);
    wait_ack(tag, a);
    chk({tag, " ack"}, 32'(a), 32'(1 << v.r));
    chk({tag, " status"}, 32'(bus.o_status), 32'(v.st));
    if (v.ck_stk) chk({tag, " stock"}, 32'(bus.o_stock), 32'(v.stk));
    @(negedge i_clk);
    bus.i_req[v.r] = 1'b0;
  endtask

  function automatic vec_t mk(int r, logic [1:0] op, logic [NB-1:0] nm,
                              logic [UB-1:0] u, logic [SB-1:0] q,
                              logic [2:0] st, logic [SB-1:0] stk,
                              bit ck);
    vec_t v;
    v.r = r; v.op = op; v.nm = nm; v.u = u; v.q = q;
    v.st = st; v.stk = stk; v.ck_stk = ck;
    return v;
  endfunction

  // ops and status codes
  localparam logic [1:0] FND = 2'd0, ADD = 2'd1, DEL = 2'd2, BUY = 2'd3;

  initial begin
    logic [NR-1:0] a;
    int n;
    bit seen;

    i_reset    = 1'b1;
    bus.i_req  = '0;
    bus.i_op   = '0;
    bus.i_name = '0;
    bus.i_user = '0;
    bus.i_qty  = '0;

    vecs.push_back(mk(0, ADD, "Pen",  1, 3, 0, 3, 1));
    vecs.push_back(mk(1, ADD, "Cup",  2, 7, 0, 7, 1));
    vecs.push_back(mk(0, ADD, "Hat",  3, 0, 0, 0, 1));
    vecs.push_back(mk(1, ADD, "Lamp", 1, 9, 3, 0, 0));
    vecs.push_back(mk(0, ADD, "Book", 5, 1, 2, 0, 0));
    vecs.push_back(mk(1, BUY, "Book", 4, 3, 0, 2, 1));
    vecs.push_back(mk(0, BUY, "Book", 4, 3, 5, 2, 1));
    vecs.push_back(mk(1, BUY, "Book", 4, 2, 0, 0, 1));
    vecs.push_back(mk(0, FND, "Book", 4, 0, 0, 0, 1));
    vecs.push_back(mk(1, BUY, "Hat",  6, 0, 0, 0, 1));
    vecs.push_back(mk(0, DEL, "Book", 3, 0, 4, 0, 0));
    vecs.push_back(mk(1, DEL, "Book", 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, FND, "Book", 2, 0, 1, 0, 1));
    vecs.push_back(mk(1, BUY, "Book", 2, 1, 1, 0, 1));
    vecs.push_back(mk(0, DEL, "Book", 2, 0, 1, 0, 1));
    vecs.push_back(mk(1, FND, "Pe",   1, 0, 1, 0, 1));
    vecs.push_back(mk(0, ADD, "Mug",  2, 4, 0, 4, 1));
    vecs.push_back(mk(1, ADD, "Rug",  2, 1, 3, 0, 0));
    vecs.push_back(mk(0, FND, "Pen",  9, 0, 0, 3, 1));
    vecs.push_back(mk(0, FND, "Cup",  9, 0, 0, 7, 1));

    #12;
    chk("reset ack",    32'(bus.o_ack),    32'd0);
    chk("reset busy",   32'(bus.o_busy),   32'd0);
    chk("reset status", 32'(bus.o_status), 32'd0);
    chk("reset stock",  32'(bus.o_stock),  32'd0);
    chk("reset grant",  32'(bus.o_grant),  32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // latency: grant edge counts as edge 1, ack follows edge 6
    @(negedge i_clk);
    drive(0, ADD, "Book", 2, 5);
    @(posedge i_clk);
    #1;
    chk("lat busy at grant", 32'(bus.o_busy), 32'd1);
    chk("lat grant", 32'(bus.o_grant), 32'd0);
    n = 1;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      @(posedge i_clk);
      #1;
      n++;
      if (bus.o_ack[0]) seen = 1'b1;
      else chk("lat no early ack", 32'(bus.o_ack), 32'd0);
    end
    chk("lat edges", 32'(n), 32'd6);
    chk("lat status", 32'(bus.o_status), 32'd0);
    chk("lat stock", 32'(bus.o_stock), 32'd5);
    chk("lat busy in ack", 32'(bus.o_busy), 32'd1);
    @(negedge i_clk);
    bus.i_req[0] = 1'b0;
    @(posedge i_clk);
    #1;
    chk("lat busy after ack", 32'(bus.o_busy), 32'd0);
    chk("lat ack one cycle", 32'(bus.o_ack), 32'd0);

    // rr now 1; a single req1 op brings it back to 0
    run(mk(1, FND, "Book", 1, 0, 0, 5, 1), "rr find");

    @(negedge i_clk);
    drive(0, FND, "Book", 1, 0);
    drive(1, FND, "Book", 2, 0);
    wait_ack("tie1 a", a);
    chk("tie1 first", 32'(a), 32'b01);
    chk("tie1 first status", 32'(bus.o_status), 32'd0);
    chk("tie1 first stock", 32'(bus.o_stock), 32'd5);
    @(negedge i_clk);
    bus.i_req[0] = 1'b0;
    wait_ack("tie1 b", a);
    chk("tie1 second", 32'(a), 32'b10);
    chk("tie1 second grant", 32'(bus.o_grant), 32'd1);
    chk("tie1 second stock", 32'(bus.o_stock), 32'd5);
    @(negedge i_clk);
    bus.i_req[1] = 1'b0;

    run(mk(0, FND, "Book", 1, 0, 0, 5, 1), "rr find0");

    @(negedge i_clk);
    drive(0, FND, "Book", 1, 0);
    drive(1, FND, "Book", 2, 0);
    wait_ack("tie2 a", a);
    chk("tie2 first", 32'(a), 32'b10);
    chk("tie2 first stock", 32'(bus.o_stock), 32'd5);
    @(negedge i_clk);
    bus.i_req[1] = 1'b0;
    wait_ack("tie2 b", a);
    chk("tie2 second", 32'(a), 32'b01);
    chk("tie2 second status", 32'(bus.o_status), 32'd0);
    @(negedge i_clk);
    bus.i_req[0] = 1'b0;

    foreach (vecs[i])
      run(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a scan
    @(negedge i_clk);
    drive(1, ADD, "Zed", 1, 1);
    @(posedge i_clk);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("abort busy before", 32'(bus.o_busy), 32'd1);
    i_reset = 1'b1;
    #1;
    chk("abort ack",    32'(bus.o_ack),    32'd0);
    chk("abort busy",   32'(bus.o_busy),   32'd0);
    chk("abort status", 32'(bus.o_status), 32'd0);
    chk("abort stock",  32'(bus.o_stock),  32'd0);
    chk("abort grant",  32'(bus.o_grant),  32'd0);
    bus.i_req = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge i_clk);
      #1;
      chk("abort no ack", 32'(bus.o_ack), 32'd0);
    end
    @(negedge i_clk);
    i_reset = 1'b0;

    run(mk(0, FND, "Pen", 1, 0, 1, 0, 1), "post reset pen");
    run(mk(1, FND, "Zed", 1, 0, 1, 0, 1), "post reset zed");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
